// File: rtl/r5p_degu_tcb_mem.sv
// TCB subordinate memory for the R5P-degu system bus.
// One request per handshake; read data and error status are returned DLY
// cycles after the transfer. Loads are size-extracted and sign/zero-extended,
// stores are merged into the addressed byte lanes. An optional wait-state FSM
// throttles tcb_rdy after every transfer to exercise manager backpressure.
module r5p_degu_tcb_mem #(
  parameter int unsigned ABW   = 32,
  parameter int unsigned DBW   = 32,
  parameter int unsigned SIZ   = 16384,
  parameter int unsigned DLY   = 1,
  parameter int unsigned WAIT  = 0,
  parameter string       FILE  = ""
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic [ABW-1:0] tcb_adr,
  input  logic [1:0]     tcb_siz,
  input  logic           tcb_uns,
  input  logic [DBW-1:0] tcb_wdt,
  output logic [DBW-1:0] tcb_rdt,
  output logic           tcb_err
);

  // word index width; a 4-byte memory still gets a 1-bit index
  localparam int unsigned AW  = $clog2(SIZ);
  localparam int unsigned WIW = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned DEP = 1 << WIW;

  localparam logic [ABW-1:0] SIZ_A    = ABW'(SIZ);
  localparam logic [1:0]     CNT_INIT = (WAIT > 0) ? 2'(WAIT - 1) : 2'd0;

  typedef enum logic {S_RDY, S_STL} state_t;

  logic [DBW-1:0] r_mem [DEP];

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_cnt;
  logic [1:0]     w_cnt_nxt;
  logic           r_rdy;

  logic           w_trn;
  logic           w_err;
  logic [1:0]     w_off;
  logic [WIW-1:0] w_widx;
  logic [3:0]     w_be;
  logic [DBW-1:0] w_wdat;
  logic [DBW-1:0] w_rdt_p0;

  logic [DLY-1:0] r_vld_p;
  logic [DBW-1:0] r_rdt_p [DLY];
  logic           r_err_p [DLY];

  // Extract a 1/2/4-byte field starting at byte lane off and extend it.
  function automatic logic [DBW-1:0] f_load(input logic [DBW-1:0] word,
                                            input logic [1:0]     off,
                                            input logic [1:0]     siz,
                                            input logic           uns);
    logic [DBW-1:0] sh;
    sh = word >> {off, 3'b000};
    case (siz)
      2'd0:    f_load = {{(DBW-8){~uns & sh[7]}}, sh[7:0]};
      2'd1:    f_load = {{(DBW-16){~uns & sh[15]}}, sh[15:0]};
      default: f_load = sh;
    endcase
  endfunction

  assign tcb_rdy = r_rdy;
  assign w_trn   = tcb_vld & r_rdy;
  assign w_off   = tcb_adr[1:0];
  assign w_widx  = tcb_adr[WIW+1:2];

  // out-of-range addresses are rejected, never aliased into the array
  assign w_err = (tcb_siz == 2'd3)
               | ((tcb_siz == 2'd1) & tcb_adr[0])
               | ((tcb_siz == 2'd2) & (|tcb_adr[1:0]))
               | (tcb_adr >= SIZ_A);

  // Byte-lane enables and lane-aligned write data for the store merge.
  always_comb begin
    w_be = 4'b0000;
    case (tcb_siz)
      2'd0:    w_be = 4'b0001 << w_off;
      2'd1:    w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
    w_wdat   = tcb_wdt << {w_off, 3'b000};
    w_rdt_p0 = (w_err | tcb_wen) ? '0 : f_load(r_mem[w_widx], w_off, tcb_siz, tcb_uns);
  end

  // Store merge: a write blocked by reset or an error leaves memory untouched.
  always_ff @(posedge clk) begin
    if (rst && w_trn && tcb_wen && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  // p0 .. p(DLY-1): response valid shift register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_trn;
      for (int i = DLY - 1; i > 0; i--) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Response data/error shift register, qualified by r_vld_p at the output.
  always_ff @(posedge clk) begin
    if (w_trn) begin
      r_rdt_p[0] <= w_rdt_p0;
      r_err_p[0] <= w_err;
    end
    for (int i = DLY - 1; i > 0; i--) begin
      r_rdt_p[i] <= r_rdt_p[i-1];
      r_err_p[i] <= r_err_p[i-1];
    end
  end

  assign tcb_rdt = r_vld_p[DLY-1] ? r_rdt_p[DLY-1] : '0;
  assign tcb_err = r_vld_p[DLY-1] ? r_err_p[DLY-1] : 1'b0;

  // Wait FSM state register; tcb_rdy is registered and held low in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RDY;
      r_cnt   <= 2'd0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdy   <= (w_state_nxt == S_RDY);
    end
  end

  // Wait FSM next state: stall WAIT cycles after each accepted transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RDY: begin
        if (w_trn && (WAIT != 0)) begin
          w_state_nxt = S_STL;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_STL: begin
        if (r_cnt == 2'd0) w_state_nxt = S_RDY;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      end
      default: w_state_nxt = S_RDY;
    endcase
  end

endmodule

// File: tb/tb_r5p_degu_tcb_mem.sv
// Bench for r5p_degu_tcb_mem: two instances (WAIT=0/DLY=1 and WAIT=2/DLY=2)
// driven by directed and random requests; a byte-level memory model predicts
// each response, which a monitor compares in the cycle it is due.
module tb_r5p_degu_tcb_mem;

  localparam int SIZ = 16384;

  typedef struct {
    int          due;
    logic [31:0] rdt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rstn = 2'b00;
  logic [1:0]  vld = 2'b00;
  logic [1:0]  rdy;
  logic [1:0]  wen = 2'b00;
  logic [1:0]  uns = 2'b00;
  logic [1:0]  err;
  logic [31:0] adr [2];
  logic [1:0]  siz [2];
  logic [31:0] wdt [2];
  logic [31:0] rdt [2];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  r5p_degu_tcb_mem #(.ABW(32), .DBW(32), .SIZ(SIZ), .DLY(1), .WAIT(0), .FILE("")) u_d0 (
    .clk(clk), .rst(rstn[0]), .tcb_vld(vld[0]), .tcb_rdy(rdy[0]), .tcb_wen(wen[0]),
    .tcb_adr(adr[0]), .tcb_siz(siz[0]), .tcb_uns(uns[0]), .tcb_wdt(wdt[0]),
    .tcb_rdt(rdt[0]), .tcb_err(err[0]));

  r5p_degu_tcb_mem #(.ABW(32), .DBW(32), .SIZ(SIZ), .DLY(2), .WAIT(2), .FILE("")) u_d1 (
    .clk(clk), .rst(rstn[1]), .tcb_vld(vld[1]), .tcb_rdy(rdy[1]), .tcb_wen(wen[1]),
    .tcb_adr(adr[1]), .tcb_siz(siz[1]), .tcb_uns(uns[1]), .tcb_wdt(wdt[1]),
    .tcb_rdt(rdt[1]), .tcb_err(err[1]));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian assembly, rule-based errors.
  function automatic void mdl_op(input int d, input logic w, input logic [31:0] a,
                                 input logic [1:0] s, input logic u, input logic [31:0] wd,
                                 output logic [31:0] r, output logic e);
    int n;
    logic [63:0] v;
    n = 1 << s;
    e = (s == 2'd3) || ((a % n) != 0) || (a >= SIZ);
    r = '0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < n; k++) mdl[d*SIZ + int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(mdl[d*SIZ + int'(a) + k]) << (8*k));
        if (!u && v[8*n-1]) v = v | (~64'd0 << (8*n));
        r = v[31:0];
      end
    end
  endfunction

  function automatic void push(input int d, input logic [31:0] r, input logic e);
    exp_t x;
    x.due = cyc + ((d == 0) ? 1 : 2);
    x.rdt = r;
    x.err = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endfunction

  // Present one request, wait (bounded) for rdy, record the expected response.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd, input bit chk);
    int          n;
    logic [31:0] r;
    logic        e;
    vld[d] = 1'b1; wen[d] = w; adr[d] = a; siz[d] = s; uns[d] = u; wdt[d] = wd;
    if (d == 0) cmp("rdy0_nogap", 32'(rdy[0]), 32'd1);
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      cmp("rdy_timeout", 32'(rdy[d]), 32'd1);
    end else begin
      mdl_op(d, w, a, s, u, wd, r, e);
      if (chk) push(d, r, e);
    end
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic rnd_op(input int d, input int region);
    logic [31:0] a;
    a = ($urandom_range(0, 9) == 0) ? 32'(SIZ + $urandom_range(0, 63)) : 32'($urandom_range(0, region - 1));
    issue(d, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, 1'b1);
  endtask

  // Monitor: every cycle each output is either the due response or idle zeros.
  always @(negedge clk) begin
    exp_t x;
    bit   hit;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        hit = 1'b0;
        if (d == 0 && q0.size() > 0 && q0[0].due <= cyc) begin x = q0.pop_front(); hit = 1'b1; end
        if (d == 1 && q1.size() > 0 && q1[0].due <= cyc) begin x = q1.pop_front(); hit = 1'b1; end
        if (hit) begin
          cmp((d == 0) ? "rsp0_lat" : "rsp1_lat", 32'(cyc), 32'(x.due));
          cmp((d == 0) ? "rsp0_rdt" : "rsp1_rdt", rdt[d], x.rdt);
          cmp((d == 0) ? "rsp0_err" : "rsp1_err", 32'(err[d]), 32'(x.err));
        end else begin
          cmp((d == 0) ? "idle0_rdt" : "idle1_rdt", rdt[d], 32'd0);
          cmp((d == 0) ? "idle0_err" : "idle1_err", 32'(err[d]), 32'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got cyc %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit          trn;
    for (int d = 0; d < 2; d++) begin adr[d] = '0; siz[d] = '0; wdt[d] = '0; end

    // reset both instances
    @(posedge clk); #1;
    mon_en = 1'b1;
    cmp("rst_rdy0", 32'(rdy[0]), 32'd0);
    cmp("rst_rdy1", 32'(rdy[1]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 2'b11;
    cmp("rst_rdy0_hold", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    cmp("rel_rdy0", 32'(rdy[0]), 32'd1);
    cmp("rel_rdy1", 32'(rdy[1]), 32'd1);

    // instance 0: initialise 0x00..0xFF, then directed cases
    for (int i = 0; i < 64; i++) issue(0, 1'b1, 32'(4*i), 2'd2, 1'b0, $urandom, 1'b1);
    issue(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h80F08001, 1'b1);
    issue(0, 1'b0, 32'h23, 2'd0, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h23, 2'd0, 1'b1, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h30, 2'd2, 1'b0, 32'h11223344, 1'b1);
    issue(0, 1'b1, 32'h31, 2'd0, 1'b0, 32'h000000AA, 1'b1);
    issue(0, 1'b1, 32'h32, 2'd1, 1'b0, 32'h00005566, 1'b1);
    issue(0, 1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h01, 2'd1, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h06, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 32'h00, 2'd3, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'(SIZ), 2'd2, 1'b0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 300; i++) rnd_op(0, 256);

    // instance 1: initialise 0x00..0x3F
    for (int i = 0; i < 16; i++) issue(1, 1'b1, 32'(4*i), 2'd2, 1'b0, $urandom, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    // vld held high: rdy must run 1,0,0,1,0,0
    vld[1] = 1'b1; wen[1] = 1'($urandom); adr[1] = 32'($urandom_range(0, 63));
    siz[1] = 2'($urandom); uns[1] = 1'($urandom); wdt[1] = $urandom;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] r;
      logic        e;
      cmp("rdy_pattern", 32'(rdy[1]), (k % 3 == 0) ? 32'd1 : 32'd0);
      trn = rdy[1];
      if (trn) begin
        mdl_op(1, wen[1], adr[1], siz[1], uns[1], wdt[1], r, e);
        push(1, r, e);
      end
      @(posedge clk); #1;
      if (trn) begin
        wen[1] = 1'($urandom); adr[1] = 32'($urandom_range(0, 63));
        siz[1] = 2'($urandom); uns[1] = 1'($urandom); wdt[1] = $urandom;
      end
    end
    vld[1] = 1'b0;
    for (int i = 0; i < 40; i++) rnd_op(1, 64);

    // reset one cycle after a read is accepted: its response must vanish
    repeat (6) @(posedge clk);
    #1;
    a = 32'h10;
    issue(1, 1'b0, a, 2'd2, 1'b0, 32'h0, 1'b0);
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    cmp("midrst_rdy_low", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1;
    cmp("midrst_rdy_rel", 32'(rdy[1]), 32'd1);
    issue(1, 1'b0, a, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, 1'b1);

    repeat (6) @(posedge clk);
    #1;
    cmp("q0_drained", 32'(q0.size()), 32'd0);
    cmp("q1_drained", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
